alu_ctrl_dm: RTL and testbench

ALU_CTRL_DM -- requirements
Module: alu_ctrl_dm

---
 rtl/alu_ctrl_dm.sv | 266 ++++++++++++++++++++++++++
 tb/tb_alu_ctrl_dm.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_dm.sv
// alu_ctrl_dm -- LA32R decode, ALU and byte-addressed data memory.
//
// Decode (combinational):
//   instr                       -> RegWrite, MemRead, MemWrite, ALUSrc,
//                                  is_auipc, is_jump, EXTOp[5:0] (one-hot),
//                                  ALUOp[11:0] (one-hot), NPCOp, WDSel,
//                                  DMType, bOp[5:0] (one-hot), rs1, rs2, rd
// ALU (combinational):
//   alu_src1, alu_src2, alu_op  -> alu_result, Zero
// Data memory (DM_BYTES bytes, little-endian):
//   clk, rstn (async, active-high clear), DMWr, addr, din, DMType_in -> dout
//   Reads are combinational; writes land on the rising clk edge.
module alu_ctrl_dm #(
  parameter int DM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rstn,
  // decode
  input  logic [31:0] instr,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        is_auipc,
  output logic        is_jump,
  output logic [5:0]  EXTOp,
  output logic [11:0] ALUOp,
  output logic [2:0]  NPCOp,
  output logic [2:0]  WDSel,
  output logic [2:0]  DMType,
  output logic [5:0]  bOp,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  // ALU
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  input  logic [11:0] alu_op,
  output logic [31:0] alu_result,
  output logic        Zero,
  // data memory
  input  logic        DMWr,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  DMType_in,
  output logic [31:0] dout
);

  localparam logic [11:0] A_ADD  = 12'h001;
  localparam logic [11:0] A_SUB  = 12'h002;
  localparam logic [11:0] A_SLT  = 12'h004;
  localparam logic [11:0] A_SLTU = 12'h008;
  localparam logic [11:0] A_AND  = 12'h010;
  localparam logic [11:0] A_NOR  = 12'h020;
  localparam logic [11:0] A_OR   = 12'h040;
  localparam logic [11:0] A_XOR  = 12'h080;
  localparam logic [11:0] A_SLL  = 12'h100;
  localparam logic [11:0] A_SRL  = 12'h200;
  localparam logic [11:0] A_SRA  = 12'h400;
  localparam logic [11:0] A_PASS = 12'h800;

  localparam logic [5:0] E_UI5  = 6'h01;
  localparam logic [5:0] E_SI12 = 6'h02;
  localparam logic [5:0] E_UI12 = 6'h04;
  localparam logic [5:0] E_SI20 = 6'h08;
  localparam logic [5:0] E_O16  = 6'h10;
  localparam logic [5:0] E_O26  = 6'h20;

  localparam logic [2:0] T_W  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_HU = 3'b010;
  localparam logic [2:0] T_B  = 3'b011;
  localparam logic [2:0] T_BU = 3'b100;

  // ---------------------------------------------------------------- decode
  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  logic [5:0]  op6;
  logic        hit;

  assign op17 = instr[31:15];
  assign op10 = instr[31:22];
  assign op7  = instr[31:25];
  assign op6  = instr[31:26];

  always_comb begin
    RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ALUSrc = 1'b0;
    is_auipc = 1'b0; is_jump = 1'b0;
    EXTOp = '0; ALUOp = '0; NPCOp = '0; WDSel = '0; DMType = '0; bOp = '0;
    rs1 = instr[9:5];
    rs2 = instr[14:10];
    rd  = instr[4:0];

    // The opcode classes live at different field widths; their prefixes do
    // not overlap, so each width is tried in turn until one matches.
    hit = 1'b1;
    case (op17)
      17'h20: ALUOp = A_ADD;
      17'h22: ALUOp = A_SUB;
      17'h24: ALUOp = A_SLT;
      17'h25: ALUOp = A_SLTU;
      17'h28: ALUOp = A_NOR;
      17'h29: ALUOp = A_AND;
      17'h2A: ALUOp = A_OR;
      17'h2B: ALUOp = A_XOR;
      17'h2E: ALUOp = A_SLL;
      17'h2F: ALUOp = A_SRL;
      17'h30: ALUOp = A_SRA;
      17'h81: begin ALUOp = A_SLL; EXTOp = E_UI5; ALUSrc = 1'b1; end
      17'h89: begin ALUOp = A_SRL; EXTOp = E_UI5; ALUSrc = 1'b1; end
      17'h91: begin ALUOp = A_SRA; EXTOp = E_UI5; ALUSrc = 1'b1; end
      default: hit = 1'b0;
    endcase
    if (hit) RegWrite = 1'b1;

    if (!hit) begin
      hit = 1'b1;
      case (op10)
        10'h008: begin ALUOp = A_SLT;  EXTOp = E_SI12; end
        10'h009: begin ALUOp = A_SLTU; EXTOp = E_SI12; end
        10'h00A: begin ALUOp = A_ADD;  EXTOp = E_SI12; end
        10'h00D: begin ALUOp = A_AND;  EXTOp = E_UI12; end
        10'h00E: begin ALUOp = A_OR;   EXTOp = E_UI12; end
        10'h00F: begin ALUOp = A_XOR;  EXTOp = E_UI12; end
        10'h0A0: begin MemRead = 1'b1; DMType = T_B;  end
        10'h0A1: begin MemRead = 1'b1; DMType = T_H;  end
        10'h0A2: begin MemRead = 1'b1; DMType = T_W;  end
        10'h0A8: begin MemRead = 1'b1; DMType = T_BU; end
        10'h0A9: begin MemRead = 1'b1; DMType = T_HU; end
        10'h0A4: begin MemWrite = 1'b1; DMType = T_B; end
        10'h0A5: begin MemWrite = 1'b1; DMType = T_H; end
        10'h0A6: begin MemWrite = 1'b1; DMType = T_W; end
        default: hit = 1'b0;
      endcase
      if (hit) begin
        ALUSrc = 1'b1;
        if (MemRead || MemWrite) begin
          ALUOp = A_ADD;
          EXTOp = E_SI12;
        end
        if (MemRead) WDSel = 3'b001;
        if (MemWrite) rs2 = instr[4:0];
        else RegWrite = 1'b1;
      end
    end

    if (!hit) begin
      hit = 1'b1;
      case (op7)
        7'b0001010: ALUOp = A_PASS;
        7'b0001110: begin ALUOp = A_ADD; is_auipc = 1'b1; end
        default: hit = 1'b0;
      endcase
      if (hit) begin
        EXTOp = E_SI20; ALUSrc = 1'b1; RegWrite = 1'b1;
      end
    end

    if (!hit) begin
      hit = 1'b1;
      case (op6)
        6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
          is_jump = 1'b1; NPCOp = 3'b001; EXTOp = E_O16;
          rs2 = instr[4:0];
          bOp = 6'(6'd1 << (op6 - 6'h16));
          if (op6 < 6'h18)      ALUOp = A_SUB;
          else if (op6 < 6'h1A) ALUOp = A_SLT;
          else                  ALUOp = A_SLTU;
        end
        6'h14: begin is_jump = 1'b1; NPCOp = 3'b010; EXTOp = E_O26; end
        6'h15: begin
          is_jump = 1'b1; NPCOp = 3'b010; EXTOp = E_O26;
          RegWrite = 1'b1; rd = 5'd1; WDSel = 3'b010;
        end
        6'h13: begin
          is_jump = 1'b1; NPCOp = 3'b011; EXTOp = E_O16; ALUOp = A_ADD;
          ALUSrc = 1'b1; RegWrite = 1'b1; WDSel = 3'b010;
        end
        default: hit = 1'b0;
      endcase
    end

    // Unknown encodings produce an all-zero decode, indices included, so a
    // bad fetch cannot leak register numbers into hazard logic downstream.
    if (!hit) begin
      RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ALUSrc = 1'b0;
      is_auipc = 1'b0; is_jump = 1'b0;
      EXTOp = '0; ALUOp = '0; NPCOp = '0; WDSel = '0; DMType = '0; bOp = '0;
      rs1 = '0; rs2 = '0; rd = '0;
    end
  end

  // ------------------------------------------------------------------- ALU
  // Any alu_op that is not exactly one-hot falls to the default (zero).
  always_comb begin
    case (alu_op)
      A_ADD:  alu_result = alu_src1 + alu_src2;
      A_SUB:  alu_result = alu_src1 - alu_src2;
      A_SLT:  alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
      A_SLTU: alu_result = {31'b0, alu_src1 < alu_src2};
      A_AND:  alu_result = alu_src1 & alu_src2;
      A_NOR:  alu_result = ~(alu_src1 | alu_src2);
      A_OR:   alu_result = alu_src1 | alu_src2;
      A_XOR:  alu_result = alu_src1 ^ alu_src2;
      A_SLL:  alu_result = alu_src1 << alu_src2[4:0];
      A_SRL:  alu_result = alu_src1 >> alu_src2[4:0];
      A_SRA:  alu_result = 32'($signed(alu_src1) >>> alu_src2[4:0]);
      A_PASS: alu_result = alu_src2;
      default: alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);

  // ----------------------------------------------------------- data memory
  localparam int AW = $clog2(DM_BYTES);

  logic [7:0]    mem [DM_BYTES];
  logic [AW-1:0] a_byte, a_half, a_word;
  logic [3:0][7:0] wlane;   // the aligned word around addr, lane 0 = low byte
  logic          addr_unused;

  assign a_byte      = addr[AW-1:0];
  assign a_half      = {addr[AW-1:1], 1'b0};
  assign a_word      = {addr[AW-1:2], 2'b00};
  assign addr_unused = ^addr[31:AW];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign wlane[k] = mem[a_word + AW'(k)];
  end

  always_comb begin
    case (DMType_in)
      T_W:  dout = wlane;
      T_H:  dout = {{16{wlane[a_half[1] * 2 + 1][7]}},
                    wlane[a_half[1] * 2 + 1], wlane[a_half[1] * 2]};
      T_HU: dout = {16'b0, wlane[a_half[1] * 2 + 1], wlane[a_half[1] * 2]};
      T_B:  dout = {{24{wlane[a_byte[1:0]][7]}}, wlane[a_byte[1:0]]};
      T_BU: dout = {24'b0, wlane[a_byte[1:0]]};
      default: dout = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < DM_BYTES; i++) mem[i] <= '0;
    end else if (DMWr) begin
      case (DMType_in)
        T_W: begin
          mem[a_word]         <= din[7:0];
          mem[a_word + AW'(1)] <= din[15:8];
          mem[a_word + AW'(2)] <= din[23:16];
          mem[a_word + AW'(3)] <= din[31:24];
        end
        T_H, T_HU: begin
          mem[a_half]          <= din[7:0];
          mem[a_half + AW'(1)] <= din[15:8];
        end
        T_B, T_BU: mem[a_byte] <= din[7:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_dm.sv
// Directed bench for alu_ctrl_dm: expected values are pushed to a scoreboard
// queue as stimulus is applied and popped when the output is sampled.
module tb_alu_ctrl_dm;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr;
  logic        RegWrite, MemRead, MemWrite, ALUSrc, is_auipc, is_jump;
  logic [5:0]  EXTOp, bOp;
  logic [11:0] ALUOp, alu_op;
  logic [2:0]  NPCOp, WDSel, DMType, DMType_in;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] alu_src1, alu_src2, alu_result, addr, din, dout;
  logic        Zero, DMWr;
  logic [53:0] dec_all;

  alu_ctrl_dm #(.DM_BYTES(128)) dut (
    .clk(clk), .rstn(rstn), .instr(instr),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .is_auipc(is_auipc), .is_jump(is_jump),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .WDSel(WDSel),
    .DMType(DMType), .bOp(bOp), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .alu_result(alu_result), .Zero(Zero),
    .DMWr(DMWr), .addr(addr), .din(din), .DMType_in(DMType_in), .dout(dout)
  );

  always #5 clk = ~clk;

  assign dec_all = {RegWrite, MemRead, MemWrite, ALUSrc, is_auipc, is_jump,
                    EXTOp, ALUOp, NPCOp, WDSel, DMType, bOp, rs1, rs2, rd};

  logic [63:0] sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic push(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic alu(input string tag, input logic [11:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r);
    alu_op = op; alu_src1 = a; alu_src2 = b;
    push(64'(r)); push(64'(r == 0));
    #1;
    chk({tag, ".res"}, 64'(alu_result));
    chk({tag, ".zero"}, 64'(Zero));
  endtask

  task automatic dm_wr(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t);
    @(negedge clk);
    DMWr = 1'b1; addr = a; din = d; DMType_in = t;
    @(posedge clk);
    #1;
    DMWr = 1'b0;
  endtask

  task automatic dm_rd(input string tag, input logic [31:0] a,
                       input logic [2:0] t, input logic [31:0] e);
    addr = a; DMType_in = t;
    push(64'(e));
    #1;
    chk(tag, 64'(dout));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1; instr = '0; alu_op = '0; alu_src1 = '0; alu_src2 = '0;
    DMWr = 1'b0; addr = '0; din = '0; DMType_in = '0;
    #12;
    dm_rd("rst.w0", 0, 3'b000, 32'h0);
    dm_rd("rst.w8", 8, 3'b000, 32'h0);
    @(negedge clk);
    rstn = 1'b0;

    // ---- decode
    instr = 32'h00101085;   // add.w r5,r4,r4
    push(1); push(12'h001); push(4); push(4); push(5); push(0); push(0);
    #1;
    chk("add.RegWrite", 64'(RegWrite));
    chk("add.ALUOp", 64'(ALUOp));
    chk("add.rs1", 64'(rs1));
    chk("add.rs2", 64'(rs2));
    chk("add.rd", 64'(rd));
    chk("add.WDSel", 64'(WDSel));
    chk("add.ALUSrc", 64'(ALUSrc));

    instr = 32'h58000C85;   // beq r4,r5
    push(1); push(3'b001); push(6'b000001); push(12'h002); push(5); push(6'h10);
    push(0);
    #1;
    chk("beq.is_jump", 64'(is_jump));
    chk("beq.NPCOp", 64'(NPCOp));
    chk("beq.bOp", 64'(bOp));
    chk("beq.ALUOp", 64'(ALUOp));
    chk("beq.rs2", 64'(rs2));
    chk("beq.EXTOp", 64'(EXTOp));
    chk("beq.RegWrite", 64'(RegWrite));

    instr = 32'h60000000;   // blt
    push(6'b000100); push(12'h004);
    #1;
    chk("blt.bOp", 64'(bOp));
    chk("blt.ALUOp", 64'(ALUOp));

    instr = 32'hFFFFFFFF;
    push(0);
    #1;
    chk("bad.all", 64'(dec_all));

    instr = 32'h28000066;   // ld.b r6, r3
    push(1); push(1); push(3'b011); push(3'b001); push(6'h02); push(12'h001);
    push(3);
    #1;
    chk("ldb.MemRead", 64'(MemRead));
    chk("ldb.RegWrite", 64'(RegWrite));
    chk("ldb.DMType", 64'(DMType));
    chk("ldb.WDSel", 64'(WDSel));
    chk("ldb.EXTOp", 64'(EXTOp));
    chk("ldb.ALUOp", 64'(ALUOp));
    chk("ldb.rs1", 64'(rs1));

    instr = 32'h29400007;   // st.h, data reg r7
    push(1); push(0); push(7); push(3'b001);
    #1;
    chk("sth.MemWrite", 64'(MemWrite));
    chk("sth.RegWrite", 64'(RegWrite));
    chk("sth.rs2", 64'(rs2));
    chk("sth.DMType", 64'(DMType));

    instr = 32'h00488000;   // srai.w
    push(12'h400); push(6'h01); push(1);
    #1;
    chk("srai.ALUOp", 64'(ALUOp));
    chk("srai.EXTOp", 64'(EXTOp));
    chk("srai.ALUSrc", 64'(ALUSrc));

    instr = 32'h03400000;   // andi
    push(6'h04); push(12'h010);
    #1;
    chk("andi.EXTOp", 64'(EXTOp));
    chk("andi.ALUOp", 64'(ALUOp));

    instr = 32'h1C000000;   // pcaddu12i
    push(1); push(6'h08); push(12'h001);
    #1;
    chk("pcadd.is_auipc", 64'(is_auipc));
    chk("pcadd.EXTOp", 64'(EXTOp));
    chk("pcadd.ALUOp", 64'(ALUOp));

    instr = 32'h14000000;   // lu12i.w
    push(12'h800); push(6'h08);
    #1;
    chk("lu12i.ALUOp", 64'(ALUOp));
    chk("lu12i.EXTOp", 64'(EXTOp));

    instr = 32'h54000000;   // bl
    push(1); push(1); push(3'b010); push(3'b010); push(6'h20);
    #1;
    chk("bl.RegWrite", 64'(RegWrite));
    chk("bl.rd", 64'(rd));
    chk("bl.WDSel", 64'(WDSel));
    chk("bl.NPCOp", 64'(NPCOp));
    chk("bl.EXTOp", 64'(EXTOp));

    instr = 32'h4C000000;   // jirl
    push(3'b011); push(3'b010); push(1);
    #1;
    chk("jirl.NPCOp", 64'(NPCOp));
    chk("jirl.WDSel", 64'(WDSel));
    chk("jirl.RegWrite", 64'(RegWrite));

    // ---- ALU
    alu("sra",   12'h400, 32'h80000000, 32'h4, 32'hF8000000);
    alu("sltu",  12'h008, 32'h80000000, 32'h4, 32'h0);
    alu("slt",   12'h004, 32'hFFFFFFFF, 32'h1, 32'h1);
    alu("add",   12'h001, 32'hFFFFFFFF, 32'h2, 32'h1);
    alu("sub",   12'h002, 32'h0, 32'h1, 32'hFFFFFFFF);
    alu("nor",   12'h020, 32'h0F0F0000, 32'h000000FF, 32'hF0F0FF00);
    alu("srl",   12'h200, 32'h80000000, 32'h24, 32'h08000000);
    alu("sll",   12'h100, 32'h00000003, 32'h1F, 32'h80000000);
    alu("pass",  12'h800, 32'h12345678, 32'hCAFE0000, 32'hCAFE0000);
    alu("multi", 12'h003, 32'h5, 32'h7, 32'h0);
    alu("none",  12'h000, 32'h5, 32'h7, 32'h0);

    // ---- data memory
    dm_wr(8, 32'h8081F2F3, 3'b000);
    dm_rd("ld.b8",   8,   3'b011, 32'hFFFFFFF3);
    dm_rd("ld.hu8",  8,   3'b010, 32'h0000F2F3);
    dm_rd("ld.bu11", 11,  3'b100, 32'h00000080);
    dm_rd("ld.h10",  10,  3'b001, 32'hFFFF8081);
    dm_rd("ld.w9",   9,   3'b000, 32'h8081F2F3);
    dm_rd("ld.wrap", 136, 3'b000, 32'h8081F2F3);
    dm_wr(13, 32'hFFFFFFAB, 3'b011);
    dm_rd("st.b13",  12,  3'b000, 32'h0000AB00);
    dm_wr(19, 32'hFFFF1234, 3'b001);
    dm_rd("st.h19",  16,  3'b000, 32'h12340000);
    dm_wr(127, 32'h000000C5, 3'b011);
    dm_rd("ld.b127", 127, 3'b011, 32'hFFFFFFC5);

    // Reset mid-cycle: contents vanish before any clock edge.
    @(negedge clk);
    #2;
    rstn = 1'b1;
    dm_rd("arst.w8",  8,  3'b000, 32'h0);
    dm_rd("arst.w16", 16, 3'b000, 32'h0);
    // A write attempted while reset is held must not land.
    @(negedge clk);
    DMWr = 1'b1; addr = 32; din = 32'hDEADBEEF; DMType_in = 3'b000;
    @(negedge clk);
    DMWr = 1'b0; rstn = 1'b0;
    dm_rd("blk.w32", 32, 3'b000, 32'h0);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: %0d expected entries left unchecked", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
